poly_sched: RTL and testbench

POLY_SCHED -- requirements
Module: poly_sched

---
 rtl/poly_pkg.sv | 46 ++++
 rtl/poly_alu.sv | 58 +++++
 rtl/poly_sched.sv | 158 +++++++++++++++
 tb/tb_poly_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// poly_pkg: shared definitions for the polynomial scheduler.
//   - DATA_W        : datapath width (8-bit, all arithmetic mod 256)
//   - state codes   : 3-bit encodings for the scheduler FSM, plus the enum
//   - ALU op codes  : add / multiply
//   - select codes  : which working register feeds an ALU input
package poly_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4 * DATA_W;

  // State encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_AX    = 3'd1;
  localparam logic [2:0] ST_AXX   = 3'd2;
  localparam logic [2:0] ST_BX    = 3'd3;
  localparam logic [2:0] ST_ADD_B = 3'd4;
  localparam logic [2:0] ST_ADD_C = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_AX    = ST_AX,
    S_AXX   = ST_AXX,
    S_BX    = ST_BX,
    S_ADD_B = ST_ADD_B,
    S_ADD_C = ST_ADD_C,
    S_DONE  = ST_DONE
  } state_e;

  // ALU operation codes
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_MUL = 1'b1;

  // ALU operand select codes
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;

  // Operand word layout: {a, b, c, x}, a in the top byte.
  function automatic logic [DATA_W-1:0] op_field(input logic [OP_W-1:0] word,
                                                 input int unsigned   idx);
    return word[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/poly_alu.sv
// poly_alu: the single shared arithmetic unit of the scheduler.
// Purely combinational: two operand select muxes over the working
// registers A/B/C/X followed by an 8-bit add or multiply (low byte kept).
// Ports:
//   a_i, b_i, c_i, x_i : working register values
//   sel0_i, sel1_i     : operand select codes (SEL_A/B/C/X)
//   op_i               : ALU_ADD or ALU_MUL
//   y_o                : result truncated to DATA_W bits
module poly_alu
  import poly_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [1:0]        sel0_i,
  input  logic [1:0]        sel1_i,
  input  logic              op_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0]   opnd0;
  logic [DATA_W-1:0]   opnd1;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   sum;

  always_comb begin
    opnd0 = a_i;
    case (sel0_i)
      SEL_A:   opnd0 = a_i;
      SEL_B:   opnd0 = b_i;
      SEL_C:   opnd0 = c_i;
      default: opnd0 = x_i;
    endcase
  end

  always_comb begin
    opnd1 = a_i;
    case (sel1_i)
      SEL_A:   opnd1 = a_i;
      SEL_B:   opnd1 = b_i;
      SEL_C:   opnd1 = c_i;
      default: opnd1 = x_i;
    endcase
  end

  // Full-width product, then keep only the low byte (mod 256).
  assign prod = opnd0 * opnd1;
  assign sum  = opnd0 + opnd1;

  always_comb begin
    y_o = sum;
    if (op_i == ALU_MUL) begin
      y_o = prod[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/poly_sched.sv
// poly_sched: two-requester round-robin scheduler that evaluates
// a*x*x + b*x + c (mod 256) on one shared ALU, one operation per cycle.
// Ports:
//   clk            : rising-edge clock
//   resetn         : synchronous active-low reset
//   req0/req1      : level requests
//   op0/op1        : operands {a, b, c, x}
//   grant0/grant1  : one-cycle pulse in the cycle after capture (S_AX)
//   done0/done1    : one-cycle pulse while result is fresh (S_DONE)
//   result         : last completed polynomial value
//   busy           : high whenever the FSM is not idle
module poly_sched
  import poly_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic [OP_W-1:0]   op0,
  input  logic [OP_W-1:0]   op1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] result_q;
  logic              owner_q;   // requester whose job is in flight
  logic              last_q;    // requester granted most recently

  logic              any_req;
  logic              winner;
  logic [OP_W-1:0]   win_op;

  logic [1:0]        alu_sel0;
  logic [1:0]        alu_sel1;
  logic              alu_op;
  logic [DATA_W-1:0] alu_y;

  // Round-robin: a sole requester wins; on a tie the one not granted
  // last time wins.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last_q : req1;
  assign win_op  = winner ? op1 : op0;

  // Next-state and ALU control.
  always_comb begin
    state_d  = state_q;
    alu_sel0 = SEL_A;
    alu_sel1 = SEL_X;
    alu_op   = ALU_MUL;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_AX;
        end
      end
      S_AX: begin
        alu_sel0 = SEL_A;
        alu_sel1 = SEL_X;
        alu_op   = ALU_MUL;
        state_d  = S_AXX;
      end
      S_AXX: begin
        alu_sel0 = SEL_A;
        alu_sel1 = SEL_X;
        alu_op   = ALU_MUL;
        state_d  = S_BX;
      end
      S_BX: begin
        alu_sel0 = SEL_B;
        alu_sel1 = SEL_X;
        alu_op   = ALU_MUL;
        state_d  = S_ADD_B;
      end
      S_ADD_B: begin
        alu_sel0 = SEL_A;
        alu_sel1 = SEL_B;
        alu_op   = ALU_ADD;
        state_d  = S_ADD_C;
      end
      S_ADD_C: begin
        alu_sel0 = SEL_A;
        alu_sel1 = SEL_C;
        alu_op   = ALU_ADD;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  poly_alu u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .c_i    (c_q),
    .x_i    (x_q),
    .sel0_i (alu_sel0),
    .sel1_i (alu_sel1),
    .op_i   (alu_op),
    .y_o    (alu_y)
  );

  // State and datapath registers. Operands are only sampled in S_IDLE,
  // so later req/op activity cannot disturb a job in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      x_q      <= '0;
      result_q <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;   // so requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            a_q     <= op_field(win_op, 3);
            b_q     <= op_field(win_op, 2);
            c_q     <= op_field(win_op, 1);
            x_q     <= op_field(win_op, 0);
            owner_q <= winner;
            last_q  <= winner;
          end
        end
        S_AX, S_AXX, S_ADD_B: a_q <= alu_y;
        S_BX:                 b_q <= alu_y;
        S_ADD_C:              result_q <= alu_y;
        default: ;
      endcase
    end
  end

  // Pulses are decoded from registered state, so they are glitch-free
  // and mutually exclusive by construction.
  assign grant0 = (state_q == S_AX)   && (owner_q == 1'b0);
  assign grant1 = (state_q == S_AX)   && (owner_q == 1'b1);
  assign done0  = (state_q == S_DONE) && (owner_q == 1'b0);
  assign done1  = (state_q == S_DONE) && (owner_q == 1'b1);
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_poly_sched.sv
// tb_poly_sched: directed, table-driven checks of poly_sched plus
// hand-written sequences for arbitration, mid-job reset and operand hold.
module tb_poly_sched;

  logic        clk;
  logic        resetn;
  logic        req0, req1;
  logic [31:0] op0, op1;
  logic        grant0, grant1, done0, done1, busy;
  logic [7:0]  result;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;
  logic [7:0] prev_result = 8'h00;

  poly_sched dut (
    .clk    (clk),
    .resetn (resetn),
    .req0   (req0),
    .req1   (req1),
    .op0    (op0),
    .op1    (op1),
    .grant0 (grant0),
    .grant1 (grant1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses of the two requesters must never coincide.
  always @(negedge clk) begin
    if ((grant0 & grant1) === 1'b1 || (done0 & done1) === 1'b1)
      overlap_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Runs one job for a single requester. Caller is just after a negedge
  // with the DUT idle; returns just after the negedge of the next S_IDLE.
  task automatic do_job(input int who, input logic [31:0] op, input logic [7:0] exp,
                        input bit corrupt, input string name);
    logic g, go, d;
    if (who == 0) begin op0 = op; req0 = 1'b1; end
    else          begin op1 = op; req1 = 1'b1; end
    @(posedge clk);
    @(negedge clk);                       // S_AX
    g  = (who == 0) ? grant0 : grant1;
    go = (who == 0) ? grant1 : grant0;
    chk({name, " grant"}, g, 1);
    chk({name, " other_grant"}, go, 0);
    chk({name, " busy"}, busy, 1);
    if (who == 0) begin req0 = 1'b0; if (corrupt) op0 = 32'hFFFF_FFFF; end
    else          begin req1 = 1'b0; if (corrupt) op1 = 32'hFFFF_FFFF; end
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      d = (who == 0) ? done0 : done1;
      if (k == 5) begin                   // S_ADD_C: nothing published yet
        chk({name, " done_early"}, d, 0);
        chk({name, " result_hold"}, result, prev_result);
      end else if (k == 6) begin          // S_DONE
        chk({name, " done"}, d, 1);
        chk({name, " result"}, result, exp);
      end
    end
    @(negedge clk);
    chk({name, " idle"}, busy, 0);
    prev_result = exp;
  endtask

  typedef struct {
    int          who;
    logic [31:0] op;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[6];

  int gwho[$], gcyc[$], dwho[$], dcyc[$];
  logic [7:0] dres[$];
  int n_done;

  initial begin
    vecs[0] = '{0, {8'd2,   8'd3,   8'd4,   8'd5},   8'h45}; // 50+15+4
    vecs[1] = '{1, {8'd3,   8'd1,   8'd0,   8'd10},  8'h36}; // 310 mod 256
    vecs[2] = '{0, {8'd0,   8'd0,   8'd0,   8'd0},   8'h00};
    vecs[3] = '{1, {8'd255, 8'd255, 8'd255, 8'd255}, 8'hFF}; // 255+1+255
    vecs[4] = '{0, {8'd1,   8'd2,   8'd3,   8'd16},  8'h23}; // 256+32+3
    vecs[5] = '{1, {8'd7,   8'd0,   8'd9,   8'd3},   8'h48}; // 63+0+9

    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst result", result, 0);
    chk("rst grants", {grant0, grant1}, 0);
    chk("rst dones", {done0, done1}, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      do_job(vecs[i].who, vecs[i].op, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));

    // Tie: fresh reset, both requesting, held for four jobs.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    prev_result = 8'h00;
    op0 = {8'd2, 8'd3, 8'd4, 8'd5};
    op1 = {8'd3, 8'd1, 8'd0, 8'd10};
    req0 = 1'b1; req1 = 1'b1;
    n_done = 0;
    for (int n = 0; n < 60 && n_done < 4; n++) begin
      @(negedge clk);
      if (grant0) begin gwho.push_back(0); gcyc.push_back(n); end
      if (grant1) begin gwho.push_back(1); gcyc.push_back(n); end
      if (gwho.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
      if (done0 || done1) begin
        dwho.push_back(done1 ? 1 : 0); dcyc.push_back(n); dres.push_back(result);
        n_done++;
      end
    end
    chk("tie grant_count", gwho.size(), 4);
    chk("tie done_count", dwho.size(), 4);
    for (int i = 0; i < 4 && i < gwho.size() && i < dwho.size(); i++) begin
      chk($sformatf("tie%0d grant_who", i), gwho[i], i % 2);
      chk($sformatf("tie%0d done_who", i), dwho[i], i % 2);
      chk($sformatf("tie%0d done_lat", i), dcyc[i] - gcyc[i], 5);
      chk($sformatf("tie%0d result", i), dres[i], (i % 2) ? 8'h36 : 8'h45);
      if (i > 0) chk($sformatf("tie%0d spacing", i), gcyc[i] - gcyc[i-1], 7);
    end
    @(negedge clk);
    chk("tie idle", busy, 0);
    prev_result = 8'h36;

    // Reset during S_BX aborts the job silently.
    op0 = {8'd2, 8'd3, 8'd4, 8'd5};
    req0 = 1'b1;
    @(posedge clk);
    @(negedge clk);                       // S_AX
    req0 = 1'b0;
    @(negedge clk);                       // S_AXX
    @(negedge clk);                       // S_BX
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort result", result, 0);
    chk("abort dones", {done0, done1}, 0);
    resetn = 1'b1;
    n_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done0 || done1 || busy) n_done++;
    end
    chk("abort quiet", n_done, 0);
    prev_result = 8'h00;
    do_job(0, {8'd1, 8'd2, 8'd3, 8'd16}, 8'h23, 1'b0, "after_abort");

    // Operands trashed right after grant must not reach the result.
    do_job(0, {8'd2, 8'd3, 8'd4, 8'd5}, 8'h45, 1'b1, "op_hold0");
    do_job(1, {8'd3, 8'd1, 8'd0, 8'd10}, 8'h36, 1'b1, "op_hold1");

    chk("no overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
